// File: rtl/hamming_pkg.sv
// Shared SEC-DED helpers: width derivation, codeword layout and syndrome math.
// Functions work on a 64-bit container so any legal CODE_W can be sliced out.
package hamming_pkg;

  localparam int unsigned MAX_W     = 64;
  localparam int unsigned MAX_PAR_W = 6;

  typedef enum logic [1:0] {
    CLEAN = 2'd0,
    SBIT  = 2'd1,
    DBIT  = 2'd2
  } err_kind_e;

  function automatic int unsigned par_w(input int unsigned code_w);
    return $clog2(code_w);
  endfunction

  function automatic int unsigned data_w(input int unsigned code_w);
    return code_w - $clog2(code_w) - 1;
  endfunction

  function automatic logic is_pow2(input int unsigned x);
    return (x != 0) && ((x & (x - 1)) == 0);
  endfunction

  // Position 0 (overall parity) is excluded from the syndrome.
  function automatic logic [MAX_PAR_W-1:0] calc_syn(input logic [MAX_W-1:0] code,
                                                    input int unsigned      code_w);
    logic [MAX_PAR_W-1:0] s;
    s = '0;
    for (int unsigned i = 1; i < MAX_W; i++) begin
      if (i < code_w && code[i]) s = s ^ MAX_PAR_W'(i);
    end
    return s;
  endfunction

  function automatic logic [MAX_W-1:0] extract_data(input logic [MAX_W-1:0] code,
                                                    input int unsigned      code_w);
    logic [MAX_W-1:0] d;
    int unsigned      j;
    d = '0;
    j = 0;
    for (int unsigned i = 1; i < MAX_W; i++) begin
      if (i < code_w && !is_pow2(i)) begin
        d[j] = code[i];
        j    = j + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/hamming_secded_dec_if.sv
// Dual-port decoder bus: codeword inputs, decoded outputs and error statistics.
interface hamming_secded_dec_if
  import hamming_pkg::*;
#(
  parameter int unsigned CODE_W = 16,
  parameter int unsigned CNT_W  = 8
);
  localparam int unsigned PAR_W  = par_w(CODE_W);
  localparam int unsigned DATA_W = data_w(CODE_W);

  logic              i_vld_a;
  logic [CODE_W-1:0] i_code_a;
  logic              i_vld_b;
  logic [CODE_W-1:0] i_code_b;
  logic              i_clr_cnt;

  logic              o_vld_a;
  logic              o_vld_b;
  logic [DATA_W-1:0] o_data_a;
  logic [DATA_W-1:0] o_data_b;
  logic [PAR_W-1:0]  o_syn_a;
  logic [PAR_W-1:0]  o_syn_b;
  logic              o_sbit_err_a;
  logic              o_sbit_err_b;
  logic              o_dbit_err_a;
  logic              o_dbit_err_b;
  logic [CNT_W-1:0]  o_scnt_a;
  logic [CNT_W-1:0]  o_scnt_b;
  logic [CNT_W-1:0]  o_dcnt_a;
  logic [CNT_W-1:0]  o_dcnt_b;

  modport master (
    output i_vld_a, i_code_a, i_vld_b, i_code_b, i_clr_cnt,
    input  o_vld_a, o_vld_b, o_data_a, o_data_b, o_syn_a, o_syn_b,
           o_sbit_err_a, o_sbit_err_b, o_dbit_err_a, o_dbit_err_b,
           o_scnt_a, o_scnt_b, o_dcnt_a, o_dcnt_b
  );

  modport slave (
    input  i_vld_a, i_code_a, i_vld_b, i_code_b, i_clr_cnt,
    output o_vld_a, o_vld_b, o_data_a, o_data_b, o_syn_a, o_syn_b,
           o_sbit_err_a, o_sbit_err_b, o_dbit_err_a, o_dbit_err_b,
           o_scnt_a, o_scnt_b, o_dcnt_a, o_dcnt_b
  );

endinterface

// File: rtl/secded_lane.sv
// One decoder port: syndrome/parity stage, correction stage, saturating counters.
module secded_lane
  import hamming_pkg::*;
#(
  parameter int unsigned CODE_W = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_clr_cnt,
  input  logic                                i_vld,
  input  logic [CODE_W-1:0]                   i_code,
  output logic                                o_vld,
  output logic [data_w(CODE_W)-1:0]           o_data,
  output logic [par_w(CODE_W)-1:0]            o_syn,
  output logic                                o_sbit_err,
  output logic                                o_dbit_err,
  output logic [CNT_W-1:0]                    o_scnt,
  output logic [CNT_W-1:0]                    o_dcnt
);
  localparam int unsigned PAR_W  = par_w(CODE_W);
  localparam int unsigned DATA_W = data_w(CODE_W);

  logic [PAR_W-1:0]  syn_in;
  logic              par_in;

  logic              vld1;
  logic [CODE_W-1:0] code1;
  logic [PAR_W-1:0]  syn1;
  logic              par1;

  err_kind_e         kind;
  logic [CODE_W-1:0] corr;
  logic [DATA_W-1:0] data_nxt;

  always_comb begin
    syn_in = PAR_W'(calc_syn(MAX_W'(i_code), CODE_W));
    par_in = ^i_code;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld1  <= 1'b0;
      code1 <= '0;
      syn1  <= '0;
      par1  <= 1'b0;
    end else begin
      vld1 <= i_vld;
      if (i_vld) begin
        code1 <= i_code;
        syn1  <= syn_in;
        par1  <= par_in;
      end
    end
  end

  // Odd overall parity means one flip at position syn1 (0 = the parity bit itself).
  always_comb begin
    kind = CLEAN;
    corr = code1;
    if (par1) begin
      kind = SBIT;
      corr = code1 ^ (CODE_W'(1) << syn1);
    end else if (syn1 != '0) begin
      kind = DBIT;
    end
    data_nxt = DATA_W'(extract_data(MAX_W'(corr), CODE_W));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_vld      <= 1'b0;
      o_data     <= '0;
      o_syn      <= '0;
      o_sbit_err <= 1'b0;
      o_dbit_err <= 1'b0;
    end else begin
      o_vld      <= vld1;
      o_sbit_err <= vld1 && (kind == SBIT);
      o_dbit_err <= vld1 && (kind == DBIT);
      if (vld1) begin
        o_data <= data_nxt;
        o_syn  <= syn1;
      end
    end
  end

  // Counters advance on the same edge that commits stage 2; clear has priority.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_scnt <= '0;
      o_dcnt <= '0;
    end else if (i_clr_cnt) begin
      o_scnt <= '0;
      o_dcnt <= '0;
    end else begin
      if (vld1 && (kind == SBIT) && (o_scnt != '1)) o_scnt <= o_scnt + 1'b1;
      if (vld1 && (kind == DBIT) && (o_dcnt != '1)) o_dcnt <= o_dcnt + 1'b1;
    end
  end

endmodule

// File: rtl/hamming_secded_dec.sv
// Dual-port SEC-DED decoder: two independent lanes sharing only the counter clear.
module hamming_secded_dec
  import hamming_pkg::*;
#(
  parameter int unsigned CODE_W = 16,
  parameter int unsigned CNT_W  = 8
) (
  input logic                i_clk,
  input logic                i_rst,
  hamming_secded_dec_if.slave bus
);

  secded_lane #(
    .CODE_W (CODE_W),
    .CNT_W  (CNT_W)
  ) u_lane_a (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr_cnt  (bus.i_clr_cnt),
    .i_vld      (bus.i_vld_a),
    .i_code     (bus.i_code_a),
    .o_vld      (bus.o_vld_a),
    .o_data     (bus.o_data_a),
    .o_syn      (bus.o_syn_a),
    .o_sbit_err (bus.o_sbit_err_a),
    .o_dbit_err (bus.o_dbit_err_a),
    .o_scnt     (bus.o_scnt_a),
    .o_dcnt     (bus.o_dcnt_a)
  );

  secded_lane #(
    .CODE_W (CODE_W),
    .CNT_W  (CNT_W)
  ) u_lane_b (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr_cnt  (bus.i_clr_cnt),
    .i_vld      (bus.i_vld_b),
    .i_code     (bus.i_code_b),
    .o_vld      (bus.o_vld_b),
    .o_data     (bus.o_data_b),
    .o_syn      (bus.o_syn_b),
    .o_sbit_err (bus.o_sbit_err_b),
    .o_dbit_err (bus.o_dbit_err_b),
    .o_scnt     (bus.o_scnt_b),
    .o_dcnt     (bus.o_dcnt_b)
  );

endmodule

// File: tb/tb_hamming_secded_dec.sv
// Directed bench for the dual-port SEC-DED decoder at CODE_W=16, CNT_W=8.
module tb_hamming_secded_dec;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hamming_secded_dec_if #(.CODE_W(16), .CNT_W(8)) bus ();

  hamming_secded_dec #(.CODE_W(16), .CNT_W(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic idle_inputs();
    bus.i_vld_a   = 1'b0;
    bus.i_code_a  = '0;
    bus.i_vld_b   = 1'b0;
    bus.i_code_b  = '0;
    bus.i_clr_cnt = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.o_vld_a !== 1'b0 || bus.o_vld_b !== 1'b0) begin errors++; $display("FAIL reset_vld: got a=%b b=%b want 0", bus.o_vld_a, bus.o_vld_b); end
    checks++; if (bus.o_data_a !== 11'h000 || bus.o_data_b !== 11'h000) begin errors++; $display("FAIL reset_data: got a=%h b=%h want 0", bus.o_data_a, bus.o_data_b); end
    checks++; if ({bus.o_scnt_a, bus.o_scnt_b, bus.o_dcnt_a, bus.o_dcnt_b} !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", {bus.o_scnt_a, bus.o_scnt_b, bus.o_dcnt_a, bus.o_dcnt_b}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean();
    @(negedge clk);
    bus.i_vld_a = 1'b1; bus.i_code_a = 16'h0000;
    bus.i_vld_b = 1'b1; bus.i_code_b = 16'hFFFF;
    @(negedge clk);
    idle_inputs();
    checks++; if (bus.o_vld_a !== 1'b0) begin errors++; $display("FAIL clean_latency1: got vld_a=%b want 0", bus.o_vld_a); end
    @(negedge clk);
    checks++; if (bus.o_vld_a !== 1'b1 || bus.o_vld_b !== 1'b1) begin errors++; $display("FAIL clean_vld: got a=%b b=%b want 1", bus.o_vld_a, bus.o_vld_b); end
    checks++; if (bus.o_data_a !== 11'h000 || bus.o_data_b !== 11'h7FF) begin errors++; $display("FAIL clean_data: got a=%h b=%h want 000/7ff", bus.o_data_a, bus.o_data_b); end
    checks++; if ({bus.o_sbit_err_a, bus.o_dbit_err_a, bus.o_sbit_err_b, bus.o_dbit_err_b} !== 4'b0) begin errors++; $display("FAIL clean_flags: got %b want 0000", {bus.o_sbit_err_a, bus.o_dbit_err_a, bus.o_sbit_err_b, bus.o_dbit_err_b}); end
    checks++; if (bus.o_syn_a !== 4'd0 || bus.o_syn_b !== 4'd0) begin errors++; $display("FAIL clean_syn: got a=%0d b=%0d want 0", bus.o_syn_a, bus.o_syn_b); end
    @(negedge clk);
    checks++; if (bus.o_vld_a !== 1'b0 || bus.o_data_b !== 11'h7FF) begin errors++; $display("FAIL clean_hold: got vld_a=%b data_b=%h want 0/7ff", bus.o_vld_a, bus.o_data_b); end
  endtask

  task automatic test_single_a();
    @(negedge clk);
    bus.i_vld_a = 1'b1; bus.i_code_a = 16'h0020;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.o_syn_a !== 4'd5 || bus.o_sbit_err_a !== 1'b1 || bus.o_dbit_err_a !== 1'b0) begin errors++; $display("FAIL sbit_a: got syn=%0d s=%b d=%b want 5/1/0", bus.o_syn_a, bus.o_sbit_err_a, bus.o_dbit_err_a); end
    checks++; if (bus.o_data_a !== 11'h000 || bus.o_scnt_a !== 8'd1) begin errors++; $display("FAIL sbit_a_data_cnt: got data=%h scnt=%0d want 000/1", bus.o_data_a, bus.o_scnt_a); end
    checks++; if (bus.o_vld_b !== 1'b0 || bus.o_scnt_b !== 8'd0) begin errors++; $display("FAIL sbit_a_isolation: got vld_b=%b scnt_b=%0d want 0/0", bus.o_vld_b, bus.o_scnt_b); end
  endtask

  task automatic test_parity_b();
    @(negedge clk);
    bus.i_vld_b = 1'b1; bus.i_code_b = 16'hFFFE;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.o_syn_b !== 4'd0 || bus.o_sbit_err_b !== 1'b1 || bus.o_dbit_err_b !== 1'b0) begin errors++; $display("FAIL parity_b: got syn=%0d s=%b d=%b want 0/1/0", bus.o_syn_b, bus.o_sbit_err_b, bus.o_dbit_err_b); end
    checks++; if (bus.o_data_b !== 11'h7FF || bus.o_scnt_b !== 8'd1) begin errors++; $display("FAIL parity_b_data_cnt: got data=%h scnt=%0d want 7ff/1", bus.o_data_b, bus.o_scnt_b); end
  endtask

  task automatic test_double_a();
    @(negedge clk);
    bus.i_vld_a = 1'b1; bus.i_code_a = 16'h0021;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.o_dbit_err_a !== 1'b1 || bus.o_sbit_err_a !== 1'b0 || bus.o_syn_a !== 4'd5) begin errors++; $display("FAIL dbit_a: got d=%b s=%b syn=%0d want 1/0/5", bus.o_dbit_err_a, bus.o_sbit_err_a, bus.o_syn_a); end
    checks++; if (bus.o_dcnt_a !== 8'd1 || bus.o_scnt_a !== 8'd1 || bus.o_data_a !== 11'h002) begin errors++; $display("FAIL dbit_a_cnt_data: got dcnt=%0d scnt=%0d data=%h want 1/1/002", bus.o_dcnt_a, bus.o_scnt_a, bus.o_data_a); end
  endtask

  // A carries clean 000F (data 001); B carries 0007, position 3 flipped.
  task automatic test_dual_port();
    @(negedge clk);
    bus.i_vld_a = 1'b1; bus.i_code_a = 16'h000F;
    bus.i_vld_b = 1'b1; bus.i_code_b = 16'h0007;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.o_data_a !== 11'h001 || bus.o_sbit_err_a !== 1'b0 || bus.o_dbit_err_a !== 1'b0) begin errors++; $display("FAIL dual_a: got data=%h s=%b d=%b want 001/0/0", bus.o_data_a, bus.o_sbit_err_a, bus.o_dbit_err_a); end
    checks++; if (bus.o_data_b !== 11'h001 || bus.o_syn_b !== 4'd3 || bus.o_sbit_err_b !== 1'b1 || bus.o_scnt_b !== 8'd2) begin errors++; $display("FAIL dual_b: got data=%h syn=%0d s=%b scnt=%0d want 001/3/1/2", bus.o_data_b, bus.o_syn_b, bus.o_sbit_err_b, bus.o_scnt_b); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [4] = '{16'h0000, 16'h0020, 16'h0021, 16'h000F};
    logic [10:0] exp_d [4] = '{11'h000, 11'h000, 11'h002, 11'h001};
    logic [3:0]  exp_s [4] = '{4'd0, 4'd5, 4'd5, 4'd0};
    logic        exp_sb[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic        exp_db[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (bus.o_vld_a !== 1'b1 || bus.o_data_a !== exp_d[i-2] || bus.o_syn_a !== exp_s[i-2] ||
            bus.o_sbit_err_a !== exp_sb[i-2] || bus.o_dbit_err_a !== exp_db[i-2]) begin
          errors++;
          $display("FAIL b2b_word%0d: got vld=%b data=%h syn=%0d s=%b d=%b want 1/%h/%0d/%b/%b", i-2,
                   bus.o_vld_a, bus.o_data_a, bus.o_syn_a, bus.o_sbit_err_a, bus.o_dbit_err_a,
                   exp_d[i-2], exp_s[i-2], exp_sb[i-2], exp_db[i-2]);
        end
      end
      if (i < 4) begin bus.i_vld_a = 1'b1; bus.i_code_a = words[i]; end
      else idle_inputs();
    end
    @(negedge clk);
    checks++; if (bus.o_vld_a !== 1'b0 || bus.o_sbit_err_a !== 1'b0 || bus.o_dbit_err_a !== 1'b0 || bus.o_data_a !== 11'h001 || bus.o_syn_a !== 4'd0) begin errors++; $display("FAIL b2b_idle: got vld=%b s=%b d=%b data=%h syn=%0d want 0/0/0/001/0", bus.o_vld_a, bus.o_sbit_err_a, bus.o_dbit_err_a, bus.o_data_a, bus.o_syn_a); end
    checks++; if (bus.o_scnt_a !== 8'd2 || bus.o_dcnt_a !== 8'd2) begin errors++; $display("FAIL b2b_cnt: got scnt=%0d dcnt=%0d want 2/2", bus.o_scnt_a, bus.o_dcnt_a); end
  endtask

  task automatic test_saturate_clear();
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      bus.i_vld_a = 1'b1; bus.i_code_a = 16'h0020;
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.o_scnt_a !== 8'hFF) begin errors++; $display("FAIL saturate: got scnt_a=%h want ff", bus.o_scnt_a); end
    @(negedge clk);
    checks++; if (bus.o_scnt_a !== 8'hFF) begin errors++; $display("FAIL saturate_hold: got scnt_a=%h want ff", bus.o_scnt_a); end
    bus.i_vld_a = 1'b1; bus.i_code_a = 16'h0020;
    @(negedge clk);
    idle_inputs();
    bus.i_clr_cnt = 1'b1;
    @(negedge clk);
    bus.i_clr_cnt = 1'b0;
    checks++; if (bus.o_sbit_err_a !== 1'b1 || bus.o_scnt_a !== 8'd0) begin errors++; $display("FAIL clear_vs_inc: got s=%b scnt_a=%0d want 1/0", bus.o_sbit_err_a, bus.o_scnt_a); end
    checks++; if (bus.o_dcnt_a !== 8'd0 || bus.o_scnt_b !== 8'd0) begin errors++; $display("FAIL clear_all: got dcnt_a=%0d scnt_b=%0d want 0/0", bus.o_dcnt_a, bus.o_scnt_b); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.i_vld_a = 1'b1; bus.i_code_a = 16'h0020;
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    checks++; if (bus.o_vld_a !== 1'b0 || bus.o_data_a !== 11'h000 || bus.o_syn_a !== 4'd0 || bus.o_sbit_err_a !== 1'b0 || bus.o_scnt_a !== 8'd0) begin errors++; $display("FAIL midreset_zero: got vld=%b data=%h syn=%0d s=%b scnt=%0d want all 0", bus.o_vld_a, bus.o_data_a, bus.o_syn_a, bus.o_sbit_err_a, bus.o_scnt_a); end
    repeat (2) begin
      @(negedge clk);
      checks++; if (bus.o_vld_a !== 1'b0) begin errors++; $display("FAIL midreset_vld: got %b want 0", bus.o_vld_a); end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_vld_a !== 1'b0) begin errors++; $display("FAIL postreset_ghost: got vld=%b want 0", bus.o_vld_a); end
    bus.i_vld_a = 1'b1; bus.i_code_a = 16'h000F;
    @(negedge clk);
    idle_inputs();
    checks++; if (bus.o_vld_a !== 1'b0) begin errors++; $display("FAIL postreset_early: got vld=%b want 0", bus.o_vld_a); end
    @(negedge clk);
    checks++; if (bus.o_vld_a !== 1'b1 || bus.o_data_a !== 11'h001 || bus.o_sbit_err_a !== 1'b0) begin errors++; $display("FAIL postreset_word: got vld=%b data=%h s=%b want 1/001/0", bus.o_vld_a, bus.o_data_a, bus.o_sbit_err_a); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_clean();
    test_single_a();
    test_parity_b();
    test_double_a();
    test_dual_port();
    test_back_to_back();
    test_saturate_clear();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
